// File: rtl/rgb_pwm_sequencer.sv
// Multi-channel PWM sequencer (off/steady/blink/breathe) with a frame-aligned config shadow.
// Optional feature: define RGB_PWM_BREATHE_EN for the per-channel breathe level ramp.
module rgb_pwm_sequencer #(
    parameter int NCH     = 3,
    parameter int PWM_W   = 8,
    parameter int PRESC_W = 16,
    parameter int BLINK_W = 8,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               hw_clk,
    input  logic               rst_n,
    input  logic [PRESC_W-1:0] presc,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [1:0]         cfg_mode,
    input  logic [PWM_W-1:0]   cfg_duty,
    input  logic [BLINK_W-1:0] cfg_period,
    output logic [NCH-1:0]     pwm_out,
    output logic               frame_tick
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STEADY  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    logic [PRESC_W-1:0] pre_cnt;
    logic [PWM_W-1:0]   pcnt;
    logic               tick;
    logic               boundary;
    logic               cfg_take;
    logic               apply;

    logic [CH_W-1:0]    sh_ch;
    mode_e              sh_mode;
    logic [PWM_W-1:0]   sh_duty;
    logic [BLINK_W-1:0] sh_period;

    mode_e              ch_mode   [NCH];
    logic [PWM_W-1:0]   ch_duty   [NCH];
    logic [BLINK_W-1:0] ch_period [NCH];
    logic [BLINK_W-1:0] step_cnt  [NCH];
    logic               blink_on  [NCH];
    logic [PWM_W-1:0]   eff       [NCH];
`ifdef RGB_PWM_BREATHE_EN
    logic [PWM_W-1:0]   level     [NCH];
    logic               falling   [NCH];
`endif

    // >= rather than == so a live lowering of presc cannot strand the prescaler.
    assign tick     = (pre_cnt >= presc);
    assign boundary = tick && (pcnt == '1);
    assign cfg_take = cfg_valid && cfg_ready && (32'(cfg_ch) < 32'(NCH));
    assign apply    = boundary && !cfg_ready;

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt    <= '0;
            pcnt       <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (tick) begin
                pre_cnt <= '0;
                pcnt    <= pcnt + PWM_W'(1);
            end else begin
                pre_cnt <= pre_cnt + PRESC_W'(1);
            end
        end
    end

    // A config taken on a boundary cycle is not yet pending, so it waits for the next one.
    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready <= 1'b1;
            sh_ch     <= '0;
            sh_mode   <= MODE_OFF;
            sh_duty   <= '0;
            sh_period <= '0;
        end else if (cfg_take) begin
            cfg_ready <= 1'b0;
            sh_ch     <= cfg_ch;
            sh_mode   <= mode_e'(cfg_mode);
            sh_duty   <= cfg_duty;
            sh_period <= cfg_period;
        end else if (apply) begin
            cfg_ready <= 1'b1;
        end
    end

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                ch_mode[i]   <= MODE_OFF;
                ch_duty[i]   <= '0;
                ch_period[i] <= '0;
                step_cnt[i]  <= '0;
                blink_on[i]  <= 1'b1;
`ifdef RGB_PWM_BREATHE_EN
                level[i]     <= '0;
                falling[i]   <= 1'b0;
`endif
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (apply && (sh_ch == CH_W'(i))) begin
                    ch_mode[i]   <= sh_mode;
                    ch_duty[i]   <= sh_duty;
                    ch_period[i] <= sh_period;
                    step_cnt[i]  <= '0;
                    blink_on[i]  <= 1'b1;
`ifdef RGB_PWM_BREATHE_EN
                    level[i]     <= '0;
                    falling[i]   <= 1'b0;
`endif
                end else if (boundary) begin
                    if (step_cnt[i] == ch_period[i]) begin
                        step_cnt[i] <= '0;
                        blink_on[i] <= !blink_on[i];
`ifdef RGB_PWM_BREATHE_EN
                        // Triangle between 0 and duty; duty 0 pins the level.
                        if (ch_duty[i] == '0) begin
                            level[i] <= '0;
                        end else if (!falling[i]) begin
                            if (level[i] >= ch_duty[i]) begin
                                falling[i] <= 1'b1;
                                level[i]   <= level[i] - PWM_W'(1);
                            end else begin
                                level[i] <= level[i] + PWM_W'(1);
                            end
                        end else begin
                            if (level[i] == '0) begin
                                falling[i] <= 1'b0;
                                level[i]   <= level[i] + PWM_W'(1);
                            end else begin
                                level[i] <= level[i] - PWM_W'(1);
                            end
                        end
`endif
                    end else begin
                        step_cnt[i] <= step_cnt[i] + BLINK_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            eff[i] = '0;
            case (ch_mode[i])
                MODE_STEADY:  eff[i] = ch_duty[i];
                MODE_BLINK:   eff[i] = blink_on[i] ? ch_duty[i] : '0;
`ifdef RGB_PWM_BREATHE_EN
                MODE_BREATHE: eff[i] = level[i];
`else
                MODE_BREATHE: eff[i] = ch_duty[i];
`endif
                default:      eff[i] = '0;
            endcase
        end
    end

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                pwm_out[i] <= (pcnt < eff[i]);
            end
        end
    end

endmodule
